// File: rtl/spi_host_cmd_pkg.sv
// Shared SPI command types.
// Lane-mode encoding used by host and device.
package spi_host_cmd_pkg;

    typedef enum logic [1:0] {
        Standard = 2'd0,
        Dual     = 2'd1,
        Quad     = 2'd2,
        RsvdSpd  = 2'd3
    } speed_t;

endpackage

// File: rtl/spi_device_shift_register_if.sv
// Byte-stream handshake between the SPI shift register
// and its client (tx fetch side and rx delivery side).
interface spi_device_shift_register_if;

    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       rx_first_o;

    modport master (
        output tx_data_i,
        output tx_valid_i,
        output rx_ready_i,
        input  tx_ready_o,
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_first_o
    );

    modport slave (
        input  tx_data_i,
        input  tx_valid_i,
        input  rx_ready_i,
        output tx_ready_o,
        output rx_data_o,
        output rx_valid_o,
        output rx_first_o
    );

endinterface

// File: rtl/spi_device_sync.sv
// Multi-flop synchronizer for asynchronous SPI pins.
// Reset value is per-instance so csb can idle high.
module spi_device_sync #(
    parameter int               Width    = 1,
    parameter int               Stages   = 2,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] ff_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Stages; i++) begin
                ff_q[i] <= ResetVal;
            end
        end else begin
            ff_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                ff_q[i] <= ff_q[i-1];
            end
        end
    end

    assign q_o = ff_q[Stages-1];

endmodule

// File: rtl/spi_device_shift_register.sv
// SPI mode-0 device shift register, 1/2/4 lanes,
// oversampled on clk_i with byte handshake to the client.
module spi_device_shift_register
    import spi_host_cmd_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sw_rst_i,
    input  logic [1:0] speed_i,
    input  logic       tx_en_i,
    input  logic       sck_i,
    input  logic       csb_i,
    input  logic [3:0] sd_i,
    output logic [3:0] sd_o,
    output logic [3:0] sd_en_o,
    spi_device_shift_register_if.slave bus,
    output logic       rx_overflow_o,
    output logic       tx_underflow_o,
    output logic       busy_o
);

    logic       sck_s, csb_s, sck_q, csb_q;
    logic [3:0] sd_s;

    spi_device_sync #(.Width(1), .Stages(SyncStages), .ResetVal(1'b0))
        u_sck (.clk_i, .rst_ni, .d_i(sck_i), .q_o(sck_s));
    spi_device_sync #(.Width(1), .Stages(SyncStages), .ResetVal(1'b1))
        u_csb (.clk_i, .rst_ni, .d_i(csb_i), .q_o(csb_s));
    spi_device_sync #(.Width(4), .Stages(SyncStages), .ResetVal(4'h0))
        u_sd (.clk_i, .rst_ni, .d_i(sd_i), .q_o(sd_s));

    // Edge-detect history tracks the pins even through soft reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q <= 1'b0;
            csb_q <= 1'b1;
        end else begin
            sck_q <= sck_s;
            csb_q <= csb_s;
        end
    end

    speed_t     spd_q, spd_now;
    logic       active_q, first_q, pend_q;
    logic [2:0] cnt_q, cnt_nx, step;
    logic [7:0] rx_sr_q, rx_nx, tx_sr_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rx_first_q, tx_ready_q;
    logic       rx_ovf_q, tx_unf_q;

    logic sel, desel, rise, fall, live;
    logic done, accept, load_tx, shift_tx;

    assign sel   = csb_q & ~csb_s;
    assign desel = ~csb_q & csb_s;
    assign rise  = ~sck_q & sck_s;
    assign fall  = sck_q & ~sck_s;

    assign spd_now = sel ? speed_t'(speed_i) : spd_q;
    assign live    = (sel | active_q) & ~csb_s & (spd_now != RsvdSpd);

    always_comb begin
        step  = 3'd1;
        rx_nx = sel ? 8'h00 : rx_sr_q;
        unique case (spd_now)
            Dual: begin
                step  = 3'd2;
                rx_nx = {rx_nx[5:0], sd_s[1:0]};
            end
            Quad: begin
                step  = 3'd4;
                rx_nx = {rx_nx[3:0], sd_s};
            end
            default: begin
                step  = 3'd1;
                rx_nx = {rx_nx[6:0], sd_s[0]};
            end
        endcase
    end

    assign cnt_nx   = (sel ? 3'd0 : cnt_q) + step;
    assign done     = rise & live & (cnt_nx == 3'd0);
    assign accept   = ~rx_valid_q | bus.rx_ready_i;
    assign load_tx  = (sel & (spd_now != RsvdSpd))
                    | (fall & live & ~sel & pend_q);
    assign shift_tx = fall & live & ~sel & ~pend_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spd_q      <= Standard;
            active_q   <= 1'b0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= 3'd0;
            rx_sr_q    <= 8'h00;
            tx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_unf_q   <= 1'b0;
        end else if (sw_rst_i) begin
            spd_q      <= Standard;
            active_q   <= 1'b0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= 3'd0;
            rx_sr_q    <= 8'h00;
            tx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_unf_q   <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            tx_unf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            if (rx_valid_q && bus.rx_ready_i) rx_valid_q <= 1'b0;

            if (sel) begin
                active_q <= 1'b1;
                spd_q    <= spd_now;
                cnt_q    <= 3'd0;
                rx_sr_q  <= 8'h00;
                first_q  <= 1'b1;
                pend_q   <= 1'b0;
            end
            if (desel) begin
                active_q <= 1'b0;
                cnt_q    <= 3'd0;
                rx_sr_q  <= 8'h00;
                pend_q   <= 1'b0;
            end

            // Rise after select so a coincident first edge is kept
            if (rise && live) begin
                rx_sr_q <= rx_nx;
                cnt_q   <= cnt_nx;
                if (done) begin
                    first_q <= 1'b0;
                    pend_q  <= 1'b1;
                    if (accept) begin
                        rx_data_q  <= rx_nx;
                        rx_first_q <= sel | first_q;
                        rx_valid_q <= 1'b1;
                    end else begin
                        rx_ovf_q <= 1'b1;
                    end
                end
            end

            if (load_tx) begin
                pend_q <= 1'b0;
                if (bus.tx_valid_i) begin
                    tx_sr_q    <= bus.tx_data_i;
                    tx_ready_q <= 1'b1;
                end else begin
                    tx_sr_q  <= 8'hFF;
                    tx_unf_q <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_sr_q <= tx_sr_q << step;
            end
        end
    end

    always_comb begin
        sd_o    = 4'h0;
        sd_en_o = 4'h0;
        unique case (spd_q)
            Standard: begin
                sd_o    = {2'b00, tx_sr_q[7], 1'b0};
                sd_en_o = 4'b0010;
            end
            Dual: begin
                sd_o    = {2'b00, tx_sr_q[7:6]};
                sd_en_o = tx_en_i ? 4'b0011 : 4'b0000;
            end
            Quad: begin
                sd_o    = tx_sr_q[7:4];
                sd_en_o = tx_en_i ? 4'b1111 : 4'b0000;
            end
            RsvdSpd: begin
                sd_o    = 4'h0;
                sd_en_o = 4'h0;
            end
        endcase
        if (!(active_q && !csb_s)) sd_en_o = 4'h0;
    end

    assign bus.tx_ready_o = tx_ready_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.rx_first_o = rx_first_q;
    assign rx_overflow_o  = rx_ovf_q;
    assign tx_underflow_o = tx_unf_q;
    assign busy_o         = ~csb_s;

endmodule

// File: tb/tb_spi_device_shift_register.sv
// Scoreboard bench: host-side SPI driver plus an rx monitor
// that pops expected {first,data} entries per presented byte.
module tb_spi_device_shift_register;
    import spi_host_cmd_pkg::*;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       tx_en = 1'b0;
    logic       sck = 1'b0;
    logic       csb = 1'b1;
    logic [3:0] sd_i = 4'h0;
    logic [3:0] sd_o, sd_en;
    logic       ovf, unf, busy;

    spi_device_shift_register_if bus ();

    spi_device_shift_register #(.SyncStages(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .sw_rst_i      (sw_rst),
        .speed_i       (speed),
        .tx_en_i       (tx_en),
        .sck_i         (sck),
        .csb_i         (csb),
        .sd_i          (sd_i),
        .sd_o          (sd_o),
        .sd_en_o       (sd_en),
        .bus           (bus),
        .rx_overflow_o (ovf),
        .tx_underflow_o(unf),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n_rdy  = 0;
    int n_unf  = 0;
    int n_ovf  = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h",
                      name, act, exp);
    endtask

    task automatic monitor();
        bit seen = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (bus.tx_ready_o) n_rdy++;
            if (unf) n_unf++;
            if (ovf) n_ovf++;
            if (bus.rx_valid_o && !seen) begin
                if (exp_q.size() == 0) begin
                    check("rx_spurious", 32'(bus.rx_valid_o), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte",
                          {23'd0, bus.rx_first_o, bus.rx_data_o},
                          {23'd0, e});
                end
            end
            seen = bus.rx_valid_o && !bus.rx_ready_i;
        end
    endtask

    task automatic sel_t(input logic [1:0] spd);
        speed = spd;
        csb = 1'b0;
        #HALF;
    endtask

    task automatic desel_t();
        csb = 1'b1;
        #HALF;
        sck = 1'b0;
        #HALF;
    endtask

    task automatic xfer(input logic [7:0] b, input int lanes,
                        input int nsteps, output logic [7:0] rd);
        logic [7:0] t;
        t = b;
        rd = 8'h00;
        for (int i = 0; i < nsteps; i++) begin
            sck = 1'b0;
            #HALF;
            case (lanes)
                2: begin
                    sd_i = {2'b00, t[7:6]};
                    rd = {rd[5:0], sd_o[1:0]};
                end
                4: begin
                    sd_i = t[7:4];
                    rd = {rd[3:0], sd_o};
                end
                default: begin
                    sd_i = {3'b000, t[7]};
                    rd = {rd[6:0], sd_o[1]};
                end
            endcase
            t = t << lanes;
            sck = 1'b1;
            #HALF;
        end
    endtask

    initial begin
        logic [7:0] rd, rd2;
        int b_rdy, b_unf, b_ovf;

        bus.tx_data_i  = 8'h00;
        bus.tx_valid_i = 1'b0;
        bus.rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_rx_valid", 32'(bus.rx_valid_o), 0);
        check("rst_rx_data", 32'(bus.rx_data_o), 0);
        check("rst_rx_first", 32'(bus.rx_first_o), 0);
        check("rst_sd_o", 32'(sd_o), 0);
        check("rst_sd_en", 32'(sd_en), 0);
        check("rst_tx_ready", 32'(bus.tx_ready_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_unf", 32'(unf), 0);

        fork
            monitor();
        join_none

        // Standard single byte
        bus.tx_data_i = 8'hA5;
        bus.tx_valid_i = 1'b1;
        b_rdy = n_rdy; b_unf = n_unf;
        exp_q.push_back({1'b1, 8'h3C});
        sel_t(2'd0);
        check("std_busy", 32'(busy), 1);
        check("std_sd_en", 32'(sd_en), 32'h2);
        xfer(8'h3C, 1, 8, rd);
        desel_t();
        check("std_host_rd", 32'(rd), 32'hA5);
        check("std_tx_ready", n_rdy - b_rdy, 1);
        check("std_no_unf", n_unf - b_unf, 0);

        // Quad two bytes
        tx_en = 1'b1;
        bus.tx_data_i = 8'h96;
        b_rdy = n_rdy;
        exp_q.push_back({1'b1, 8'h5A});
        exp_q.push_back({1'b0, 8'hC3});
        sel_t(2'd2);
        check("quad_sd_en", 32'(sd_en), 32'hF);
        xfer(8'h5A, 4, 2, rd);
        xfer(8'hC3, 4, 2, rd2);
        desel_t();
        check("quad_rd0", 32'(rd), 32'h96);
        check("quad_rd1", 32'(rd2), 32'h96);
        check("quad_tx_ready", n_rdy - b_rdy, 2);

        // Dual single byte
        bus.tx_data_i = 8'h2D;
        exp_q.push_back({1'b1, 8'hB4});
        sel_t(2'd1);
        check("dual_sd_en", 32'(sd_en), 32'h3);
        xfer(8'hB4, 2, 4, rd);
        desel_t();
        check("dual_host_rd", 32'(rd), 32'h2D);
        tx_en = 1'b0;

        // Overflow: client stalls, second byte dropped
        bus.rx_ready_i = 1'b0;
        bus.tx_data_i = 8'hA5;
        b_ovf = n_ovf; b_rdy = n_rdy;
        exp_q.push_back({1'b1, 8'h11});
        sel_t(2'd0);
        xfer(8'h11, 1, 8, rd);
        xfer(8'h22, 1, 8, rd);
        desel_t();
        check("ovf_pulses", n_ovf - b_ovf, 1);
        check("ovf_held_valid", 32'(bus.rx_valid_o), 1);
        check("ovf_held_data", 32'(bus.rx_data_o), 32'h11);
        check("ovf_tx_ready", n_rdy - b_rdy, 2);
        bus.rx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf_drained", 32'(bus.rx_valid_o), 0);

        // Underflow at select
        bus.tx_valid_i = 1'b0;
        b_unf = n_unf; b_rdy = n_rdy;
        exp_q.push_back({1'b1, 8'h55});
        sel_t(2'd0);
        xfer(8'h55, 1, 8, rd);
        desel_t();
        check("unf_host_rd", 32'(rd), 32'hFF);
        check("unf_pulses", n_unf - b_unf, 1);
        check("unf_no_ready", n_rdy - b_rdy, 0);

        // Abort after 5 bits, then clean byte
        bus.tx_valid_i = 1'b1;
        sel_t(2'd0);
        xfer(8'hFF, 1, 5, rd);
        csb = 1'b1;
        #HALF;
        check("abort_sd_en", 32'(sd_en), 0);
        check("abort_rx_valid", 32'(bus.rx_valid_o), 0);
        check("abort_busy", 32'(busy), 0);
        sck = 1'b0;
        #HALF;
        exp_q.push_back({1'b1, 8'h81});
        sel_t(2'd0);
        xfer(8'h81, 1, 8, rd);
        desel_t();
        check("abort_next_rd", 32'(rd), 32'hA5);

        // Reserved speed: inert transaction
        b_rdy = n_rdy;
        sel_t(2'd3);
        check("rsvd_sd_en", 32'(sd_en), 0);
        xfer(8'hFF, 1, 8, rd);
        desel_t();
        check("rsvd_host_rd", 32'(rd), 0);
        check("rsvd_no_ready", n_rdy - b_rdy, 0);

        // Soft reset with buffered byte and partial byte
        bus.rx_ready_i = 1'b0;
        exp_q.push_back({1'b1, 8'hA0});
        sel_t(2'd0);
        xfer(8'hA0, 1, 8, rd);
        xfer(8'h0F, 1, 3, rd);
        check("swr_pre_valid", 32'(bus.rx_valid_o), 1);
        @(negedge clk);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        check("swr_rx_valid", 32'(bus.rx_valid_o), 0);
        check("swr_rx_data", 32'(bus.rx_data_o), 0);
        check("swr_rx_first", 32'(bus.rx_first_o), 0);
        check("swr_sd_en", 32'(sd_en), 0);
        check("swr_sd_o", 32'(sd_o), 0);
        desel_t();
        bus.rx_ready_i = 1'b1;

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_device_shift_register.md
SPI_DEVICE_SHIFT_REGISTER -- requirements
Module: spi_device_shift_register

Interface
REQ-001 SHALL have parameter SyncStages, default 2, meaning flop count of sck/csb/sd input synchronizers (min 2).
REQ-002 SHALL have ports: clk_i  in  1  system clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: sw_rst_i  in  1  synchronous soft reset; speed_i  in  2  lane mode (Standard/Dual/Quad/RsvdSpd); tx_en_i  in  1  drive enable for Dual/Quad.
REQ-004 SHALL have ports: sck_i  in  1  SPI clock pin; csb_i  in  1  chip select, active-low; sd_i  in  4  data pins in; sd_o  out  4  data pins out; sd_en_o  out  4  per-pin output enable.
REQ-005 SHALL have ports: tx_data_i  in  8  next byte to send; tx_valid_i  in  1; tx_ready_o  out  1  one-cycle fetch strobe.
REQ-006 SHALL have ports: rx_data_o  out  8; rx_valid_o  out  1; rx_ready_i  in  1; rx_first_o  out  1  byte is first since select.
REQ-007 SHALL have ports: rx_overflow_o  out  1  pulse; tx_underflow_o  out  1  pulse; busy_o  out  1  selected.

Function
REQ-008 SHALL synchronize sck_i, csb_i, sd_i through SyncStages flops each, equal delay; clk_i frequency SHALL be >= 4x sck frequency.
REQ-009 SHALL detect, on synchronized signals, select (csb 1->0), deselect (csb 0->1), sck rise and sck fall; edges SHALL count only while selected.
REQ-010 SHALL operate SPI mode 0: sample on sck rise, update output on sck fall.
REQ-011 SHALL latch speed_i at select; lanes per edge N = 1/2/4 for Standard/Dual/Quad; RsvdSpd SHALL disable shifting, rx, tx and outputs for that transaction.
REQ-012 SHALL on select load tx shift register with tx_data_i and pulse tx_ready_o if tx_valid_i, else load 8'hFF and pulse tx_underflow_o; bit counter cleared; first-byte flag set.
REQ-013 SHALL on rise shift rx register left by N, inserting sd[0] (Standard), sd[1:0] (Dual), sd[3:0] (Quad); bit counter += N modulo 8.
REQ-014 SHALL on a rise that wraps counter to 0 complete a byte: if buffer empty or rx_valid_o&rx_ready_i same cycle, rx_data_o/rx_first_o load next cycle with rx_valid_o=1; else byte dropped and rx_overflow_o pulses one cycle.
REQ-015 SHALL clear first-byte flag when a byte completes (accepted or dropped).
REQ-016 SHALL hold rx_valid_o until rx_valid_o&rx_ready_i; deselect SHALL not clear a buffered byte.
REQ-017 SHALL on fall following byte completion load next tx byte per REQ-012 rules; other falls shift tx register left by N.
REQ-018 SHALL drive sd_o from tx MSBs: Standard {2'b0,sr[7],1'b0}; Dual {2'b0,sr[7:6]}; Quad sr[7:4].
REQ-019 SHALL drive sd_en_o while selected: Standard 4'b0010; Dual 4'b0011 if tx_en_i; Quad 4'b1111 if tx_en_i; else 0.
REQ-020 SHALL on deselect mid-byte discard partial rx bits, clear counter, set sd_en_o=0 same cycle csb sync shows high, no rx_valid_o.
REQ-021 SHALL treat simultaneous select and deselect detection impossible; select detected with rise same cycle: select actions first, then rise.
REQ-022 SHALL drive busy_o = synchronized csb low.

Reset
REQ-023 SHALL on rst_ni low reset: csb syncs 1, sck/sd syncs 0, shift registers 0, counter 0, all outputs 0.
REQ-024 SHALL on sw_rst_i clear all state except synchronizers to reset values next cycle, including buffered rx byte; overrides all other events.

Structure
REQ-025 SHALL import speed enum (Standard, Dual, Quad, RsvdSpd) from shared spi_host_cmd_pkg; no new package types.
REQ-026 SHALL instantiate sub-module spi_device_sync (parameterized multi-flop synchronizer) for sck, csb, sd.

Verification
REQ-027 Standard, tx_data_i=8'hA5 valid, host sends 8'h3C -> host reads 8'hA5; rx_data_o=8'h3C, rx_first_o=1, one tx_ready_o pulse.
REQ-028 Quad, host sends 8'h5A,8'hC3 with rx_ready_i=1 -> two rx bytes, rx_first_o 1 then 0; sd_en_o=4'hF with tx_en_i=1.
REQ-029 rx_ready_i=0, two Standard bytes -> first byte held, second dropped, one rx_overflow_o pulse.
REQ-030 tx_valid_i=0 at select -> tx_underflow_o pulse, host reads 8'hFF.
REQ-031 deselect after 5 bits -> no rx_valid_o, sd_en_o=0; next transaction byte 8'h81 received intact.
REQ-032 sw_rst_i mid-byte with buffered byte -> rx_valid_o=0, outputs 0 next cycle.
